// File: rtl/bcd_subtractor16_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the digit-serial BCD
//               subtractor:
//               - bcd_digit_t  : one packed-BCD digit
//               - state_t      : controller states
//               - is_bad_digit : flags a digit code above 9
//               Optional build macro: BCD_SUB_CHECK_EN (used by the top).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_RADIX     = 4'd10;
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic is_bad_digit(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_subtractor16_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_subtractor16_serial_if
// Description : Operand/result handshake bundle of the serial BCD subtractor.
//               Operand side : in_valid, in_ready, a, b, bin
//               Result side  : out_valid, out_ready, diff, bout, err
//               master : the producer/consumer around the subtractor
//               slave  : the subtractor itself
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_subtractor16_serial_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   diff;
    logic                  bout;
    logic                  err;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, err
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_subtractor16_serial_digit_sub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_sub
// Description : Combinational single-digit BCD subtract, d = a_d - b_d - brw_in
//               with ten's-complement wrap on borrow.
//               Inputs  : a_d, b_d (BCD digits), brw_in (borrow in)
//               Outputs : d (result digit), brw_out (borrow out),
//                         bad (either operand digit above 9)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  wire bcd_digit_t a_d,
    input  wire bcd_digit_t b_d,
    input  wire logic       brw_in,
    output bcd_digit_t      d,
    output logic            brw_out,
    output logic            bad
);
    // Range of a_d - b_d - brw_in is -16..15, so 5 bits two's complement
    // hold it exactly and bit 4 is the sign.
    logic [4:0] w_t;

    assign w_t     = {1'b0, a_d} - {1'b0, b_d} - {4'd0, brw_in};
    assign brw_out = w_t[4];
    // Negative: add the radix back; the 4-bit truncation is intentional.
    assign d       = w_t[4] ? (w_t[3:0] + BCD_RADIX) : w_t[3:0];
    assign bad     = is_bad_digit(a_d) | is_bad_digit(b_d);

endmodule
`default_nettype wire

// File: rtl/bcd_subtractor16_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_subtractor16_serial
// Description : Digit-serial packed-BCD subtractor, diff = a - b - bin,
//               one digit per clock, least significant digit first.
//               bout=1 means a < b + bin and diff is the ten's complement.
//               Ports : clk, rst_n (async, active-low),
//                       bus (slave modport of bcd_subtractor16_serial_if)
//               Macro : BCD_SUB_CHECK_EN - when defined, err flags any
//                       operand digit above 9 (captured at acceptance);
//                       otherwise err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor16_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    bcd_subtractor16_serial_if.slave   bus
);
    localparam int c_w    = 4 * DIGITS;
    localparam int c_idxw = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idxw-1:0] c_last = c_idxw'(DIGITS - 1);

    state_t             r_state;
    logic [c_idxw-1:0]  r_idx;
    logic [c_w-1:0]     r_a;
    logic [c_w-1:0]     r_b;
    logic               r_brw;
    logic [c_w-1:0]     r_diff;
    logic               r_bout;
    logic               r_in_ready;
    logic               r_out_valid;

    bcd_digit_t         w_a_d;
    bcd_digit_t         w_b_d;
    bcd_digit_t         w_d;
    logic               w_brw_out;
    logic               w_digit_bad;
    logic               w_accept;
    logic               w_release;

    // One shared digit slice, steered by idx.
    assign w_a_d = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_d = r_b[{r_idx, 2'b00} +: 4];

    bcd_digit_sub u_digit_sub (
        .a_d     (w_a_d),
        .b_d     (w_b_d),
        .brw_in  (r_brw),
        .d       (w_d),
        .brw_out (w_brw_out),
        .bad     (w_digit_bad)
    );

    // Operands are screened as a whole at acceptance, so the per-digit flag
    // of the shared slice is not needed here.
    logic w_unused_bad;
    assign w_unused_bad = w_digit_bad;

    assign w_accept  = (r_state == IDLE) && bus.in_valid && r_in_ready;
    assign w_release = (r_state == DONE) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_brw       <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_brw      <= bus.bin;
                        r_idx      <= '0;
                        r_diff     <= '0;
                        r_bout     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_diff[{r_idx, 2'b00} +: 4] <= w_d;
                    r_brw                       <= w_brw_out;
                    if (r_idx == c_last) begin
                        r_idx       <= '0;
                        r_bout      <= w_brw_out;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef BCD_SUB_CHECK_EN
    logic r_err;
    logic w_in_bad;

    always_comb begin
        w_in_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            w_in_bad = w_in_bad | is_bad_digit(bus.a[4*k +: 4])
                                | is_bad_digit(bus.b[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_in_bad;
        end else if (w_release) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;

endmodule
`default_nettype wire
